// File: rtl/calc_if.sv
// Token/result bundle between the keyboard token mux side and the calculator sequencer.
// master drives tokens and observes results; slave is the sequencer.
interface calc_if #(
    parameter int WIDTH = 8
);
    logic                 valid;
    logic [WIDTH-1:0]     data;
    logic [2*WIDTH-1:0]   result;
    logic                 sign;
    logic                 res_valid;
    logic                 err;
    logic [1:0]           stage;

    modport master (
        output valid, data,
        input  result, sign, res_valid, err, stage
    );

    modport slave (
        input  valid, data,
        output result, sign, res_valid, err, stage
    );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator sequencer: accepts A / operator / B tokens and presents a registered result.
// Define CALC_DIV_EN to add an iterative restoring divider on operator code OP_DIV.
module calc_sequencer #(
    parameter int         WIDTH  = 8,
    parameter logic [3:0] OP_ADD = 4'ha,
    parameter logic [3:0] OP_SUB = 4'hb,
    parameter logic [3:0] OP_MUL = 4'hc,
    parameter logic [3:0] OP_CLR = 4'hd,
    parameter logic [3:0] OP_DIV = 4'hf
) (
    input  logic  clk,
    input  logic  rst,
    calc_if.slave bus
);
    localparam int RW = 2 * WIDTH;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_OP = 3'd1,
        WAIT_B  = 3'd2,
        EXEC    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [3:0]       op_q, op_d;
    logic             op_ill_q, op_ill_d;
    logic [RW-1:0]    result_q, result_d;
    logic             sign_q, sign_d;
    logic             err_q, err_d;
    logic             res_valid_q, res_valid_d;
    logic [1:0]       stage_q, stage_d;
    logic [3:0]       code_s;
    logic [RW:0]      alu_s;

`ifdef CALC_DIV_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_shift_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic             last_step_s;
    logic             div_op_s;
`endif

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_MUL: ok = 1'b1;
`ifdef CALC_DIV_EN
            OP_DIV:                 ok = 1'b1;
`else
            OP_DIV:                 ok = 1'b0;
`endif
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Returns {sign, magnitude}; subtract reports |A-B| with the sign split out.
    function automatic logic [RW:0] alu(input logic [3:0] op,
                                        input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b);
        logic [RW-1:0] ax;
        logic [RW-1:0] bx;
        logic [RW-1:0] r;
        logic          s;
        ax = {{WIDTH{1'b0}}, a};
        bx = {{WIDTH{1'b0}}, b};
        r  = {RW{1'b0}};
        s  = 1'b0;
        case (op)
            OP_ADD: r = ax + bx;
            OP_SUB: begin
                if (a < b) begin
                    r = bx - ax;
                    s = 1'b1;
                end else begin
                    r = ax - bx;
                    s = 1'b0;
                end
            end
            OP_MUL:  r = ax * bx;
            default: r = {RW{1'b0}};
        endcase
        return {s, r};
    endfunction

    assign code_s = bus.data[3:0];
    assign alu_s  = alu(op_q, a_q, bus.data);

`ifdef CALC_DIV_EN
    assign div_op_s    = (op_q == OP_DIV);
    assign last_step_s = (cnt_q == CW'(WIDTH - 1));

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q, quo_q[WIDTH-1]};
        if (rem_shift_s >= {1'b0, b_q}) begin
            rem_next_s = WIDTH'(rem_shift_s - {1'b0, b_q});
            quo_next_s = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next_s = rem_shift_s[WIDTH-1:0];
            quo_next_s = {quo_q[WIDTH-2:0], 1'b0};
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: step through A/op/B, skip B's result on a bad operator, wait out the divider.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_A: begin
                if (bus.valid) state_d = WAIT_OP;
                else           state_d = WAIT_A;
            end
            WAIT_OP: begin
                if (!bus.valid)            state_d = WAIT_OP;
                else if (code_s == OP_CLR) state_d = WAIT_A;
                else                       state_d = WAIT_B;
            end
            WAIT_B: begin
                if (!bus.valid)    state_d = WAIT_B;
                else if (op_ill_q) state_d = WAIT_A;
`ifdef CALC_DIV_EN
                else if (div_op_s && (bus.data != {WIDTH{1'b0}})) state_d = EXEC;
`endif
                else               state_d = DONE;
            end
            EXEC: begin
`ifdef CALC_DIV_EN
                if (last_step_s) state_d = DONE;
                else             state_d = EXEC;
`else
                state_d = WAIT_A;
`endif
            end
            DONE:    state_d = WAIT_A;
            default: state_d = WAIT_A;
        endcase
    end

    // Outputs decoded from the next state so stage and res_valid come straight from flops.
    always_comb begin
        res_valid_d = 1'b0;
        stage_d     = 2'd0;
        case (state_d)
            WAIT_A:  stage_d = 2'd0;
            WAIT_OP: stage_d = 2'd1;
            WAIT_B:  stage_d = 2'd2;
            EXEC:    stage_d = 2'd3;
            DONE: begin
                stage_d     = 2'd3;
                res_valid_d = 1'b1;
            end
            default: stage_d = 2'd0;
        endcase
    end

    // Datapath: operand/operator capture, result and flag updates.
    always_comb begin
        a_d      = a_q;
        op_d     = op_q;
        op_ill_d = op_ill_q;
        result_d = result_q;
        sign_d   = sign_q;
        err_d    = err_q;
`ifdef CALC_DIV_EN
        b_d      = b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            WAIT_A: begin
                if (bus.valid) begin
                    a_d   = bus.data;
                    err_d = 1'b0;
                end else begin
                    a_d = a_q;
                end
            end
            WAIT_OP: begin
                if (!bus.valid) begin
                    op_d = op_q;
                end else if (code_s == OP_CLR) begin
                    result_d = {RW{1'b0}};
                    sign_d   = 1'b0;
                    err_d    = 1'b0;
                end else if (op_legal(code_s)) begin
                    op_d     = code_s;
                    op_ill_d = 1'b0;
                end else begin
                    // Still consume a B token so we stay in step with the mux.
                    op_d     = code_s;
                    op_ill_d = 1'b1;
                    err_d    = 1'b1;
                end
            end
            WAIT_B: begin
                if (!bus.valid || op_ill_q) begin
                    result_d = result_q;
`ifdef CALC_DIV_EN
                end else if (div_op_s) begin
                    b_d   = bus.data;
                    rem_d = {WIDTH{1'b0}};
                    quo_d = a_q;
                    cnt_d = {CW{1'b0}};
                    if (bus.data == {WIDTH{1'b0}}) begin
                        result_d = {RW{1'b0}};
                        sign_d   = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        result_d = result_q;
                    end
`endif
                end else begin
                    result_d = alu_s[RW-1:0];
                    sign_d   = alu_s[RW];
                end
            end
`ifdef CALC_DIV_EN
            EXEC: begin
                rem_d = rem_next_s;
                quo_d = quo_next_s;
                cnt_d = cnt_q + CW'(1);
                if (last_step_s) begin
                    result_d = {rem_next_s, quo_next_s};
                    sign_d   = 1'b0;
                end else begin
                    result_d = result_q;
                end
            end
`endif
            default: result_d = result_q;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= {WIDTH{1'b0}};
            op_q        <= 4'h0;
            op_ill_q    <= 1'b0;
            result_q    <= {RW{1'b0}};
            sign_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            stage_q     <= 2'd0;
        end else begin
            a_q         <= a_d;
            op_q        <= op_d;
            op_ill_q    <= op_ill_d;
            result_q    <= result_d;
            sign_q      <= sign_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            stage_q     <= stage_d;
        end
    end

`ifdef CALC_DIV_EN
    // Divider working registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_q   <= {WIDTH{1'b0}};
            rem_q <= {WIDTH{1'b0}};
            quo_q <= {WIDTH{1'b0}};
            cnt_q <= {CW{1'b0}};
        end else begin
            b_q   <= b_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.result    = result_q;
    assign bus.sign      = sign_q;
    assign bus.res_valid = res_valid_q;
    assign bus.err       = err_q;
    assign bus.stage     = stage_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: directed and random token sequences
// against an arithmetic reference model of the calculator's visible state.
module tb_calc_sequencer;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // Reference model of the externally visible held state.
    logic [15:0] m_result;
    logic        m_sign;
    logic        m_err;

    calc_if #(.WIDTH(WIDTH)) bus ();

    calc_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic exp_rv, input logic [1:0] exp_stage);
        check({tag, ".result"},    32'(bus.result),    32'(m_result));
        check({tag, ".sign"},      32'(bus.sign),      32'(m_sign));
        check({tag, ".err"},       32'(bus.err),       32'(m_err));
        check({tag, ".res_valid"}, 32'(bus.res_valid), 32'(exp_rv));
        check({tag, ".stage"},     32'(bus.stage),     32'(exp_stage));
    endtask

    // Called at a falling edge; presents one token for exactly one rising edge.
    task automatic send(input logic [7:0] d);
        bus.valid = 1'b1;
        bus.data  = d;
        @(negedge clk);
        bus.valid = 1'b0;
        bus.data  = 8'($urandom_range(0, 255));
    endtask

    task automatic run_clear(input logic [7:0] a, input logic [7:0] opd);
        send(a);
        m_err = 1'b0;
        check_all("clrA", 1'b0, 2'd1);
        send(opd);
        m_result = 16'd0;
        m_sign   = 1'b0;
        m_err    = 1'b0;
        check_all("clr", 1'b0, 2'd0);
    endtask

    task automatic run_calc(input logic [7:0] a, input logic [7:0] opd, input logic [7:0] b);
        logic [3:0]  op;
        logic        legal;
        logic [15:0] e_result;
        logic        e_sign;
        logic        e_err;
        int          diff;
        int          lat;
        op    = opd[3:0];
        legal = (op == 4'ha) || (op == 4'hb) || (op == 4'hc);
`ifdef CALC_DIV_EN
        if (op == 4'hf) legal = 1'b1;
`endif
        send(a);
        m_err = 1'b0;
        check_all("A", 1'b0, 2'd1);
        send(opd);
        if (!legal) m_err = 1'b1;
        check_all("op", 1'b0, 2'd2);
        send(b);
        if (!legal) begin
            check_all("Bill", 1'b0, 2'd0);
            return;
        end
        lat      = 1;
        e_sign   = 1'b0;
        e_err    = 1'b0;
        e_result = 16'd0;
        case (op)
            4'ha: e_result = 16'(int'(a) + int'(b));
            4'hb: begin
                diff     = int'(a) - int'(b);
                e_sign   = (diff < 0);
                e_result = 16'((diff < 0) ? -diff : diff);
            end
            4'hc: e_result = 16'(int'(a) * int'(b));
            default: begin
                if (b == 8'd0) begin
                    e_err = 1'b1;
                end else begin
                    e_result = {8'(int'(a) % int'(b)), 8'(int'(a) / int'(b))};
                    lat      = WIDTH + 1;
                end
            end
        endcase
        for (int i = 1; i < lat; i++) begin
            check("exec.res_valid", 32'(bus.res_valid), 32'd0);
            check("exec.stage", 32'(bus.stage), 32'd3);
            if (i == 2) begin
                send(8'd99);
            end else begin
                @(negedge clk);
            end
        end
        m_result = e_result;
        m_sign   = e_sign;
        m_err    = e_err;
        check_all("res", 1'b1, 2'd3);
        // A token offered during DONE must be dropped.
        send(8'd77);
        check_all("post", 1'b0, 2'd0);
    endtask

    initial begin
        int         r;
        logic [3:0] code;
        logic [7:0] ra;
        logic [7:0] rb;
        rst       = 1'b1;
        bus.valid = 1'b0;
        bus.data  = 8'd0;
        m_result  = 16'd0;
        m_sign    = 1'b0;
        m_err     = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 1'b0, 2'd0);
        rst = 1'b0;
        @(negedge clk);
        check_all("idle", 1'b0, 2'd0);

        run_calc(8'd25, 8'h0a, 8'd17);
        run_calc(8'd3, 8'h0b, 8'd200);
        run_calc(8'd255, 8'h0c, 8'd255);
        run_calc(8'd40, 8'h0b, 8'd40);
        run_clear(8'd9, 8'h0d);
        run_calc(8'd4, 8'h0a, 8'd6);
        run_calc(8'd5, 8'h01, 8'd7);
        run_calc(8'd10, 8'h3b, 8'd30);
        run_calc(8'h0d, 8'hfa, 8'h0d);
        run_calc(8'd200, 8'h0f, 8'd7);
        run_calc(8'd13, 8'h0f, 8'd0);
        run_calc(8'd1, 8'h0e, 8'd1);

        // Reset while waiting for B: everything returns to zero and B is not consumed.
        send(8'd50);
        send(8'h0c);
        #2 rst = 1'b1;
        #1;
        m_result = 16'd0;
        m_sign   = 1'b0;
        m_err    = 1'b0;
        check_all("rstB", 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_all("afterRst", 1'b0, 2'd0);
        end
        run_calc(8'd6, 8'h0c, 8'd7);

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            case (r)
                0, 1, 2: code = 4'ha;
                3, 4:    code = 4'hb;
                5, 6:    code = 4'hc;
                7:       code = 4'hd;
                8: begin
                    code = 4'($urandom_range(0, 10));
                    if (code == 4'ha) code = 4'he;
                end
                default: code = 4'hf;
            endcase
            if (code == 4'hd) begin
                run_clear(ra, {4'($urandom_range(0, 15)), code});
            end else begin
                run_calc(ra, {4'($urandom_range(0, 15)), code}, rb);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Downstream consumer of the keyboard token mux.
- Receives a stream of 8-bit tokens, each qualified by a one-cycle `valid` pulse, in the order operand A, operator, operand B.
- Executes the arithmetic and presents a registered 16-bit result, with sign and error flags, to the display stage.
- Tracks token position with its own FSM, aligned to the mux's 3-phase cycle (A, op, B), including the clear operator.

Parameters:
- WIDTH, 8, operand and token width; result width is 2*WIDTH.
- OP_ADD, 4'ha, add operator code.
- OP_SUB, 4'hb, subtract operator code.
- OP_MUL, 4'hc, multiply operator code.
- OP_CLR, 4'hd, clear operator code.
- OP_DIV, 4'hf, divide operator code (only with CALC_DIV_EN).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid  in  1  one-cycle token strobe from the keyboard mux.
- data  in  WIDTH  token: operand value, or operator code in data[3:0].
- result  out  2*WIDTH  last computed result (magnitude).
- sign  out  1  1 = result is negative (subtract only).
- res_valid  out  1  one-cycle pulse when result/sign/err update.
- err  out  1  sticky error: illegal operator or divide by zero.
- stage  out  2  next expected token: 0 = A, 1 = op, 2 = B, 3 = busy.

Behaviour:
- Reset (async, rst=1):
  - Outputs: result=0, sign=0, res_valid=0, err=0, stage=0.
  - Internal: FSM=WAIT_A, A/B/op registers=0.
  - Reset asserted mid-division aborts it with no res_valid.
- States: WAIT_A, WAIT_OP, WAIT_B, EXEC, DONE. stage = 0/1/2/3/3 respectively.
- Token acceptance: a token is accepted only on a cycle with valid=1 in WAIT_A/WAIT_OP/WAIT_B. valid in EXEC or DONE is dropped with no state change.
- WAIT_A + valid:
  - A <= data; err <= 0; -> WAIT_OP.
  - A has no special codes; data=8'h0d is a plain number.
- WAIT_OP + valid, by data[3:0]:
  - OP_CLR: result <= 0, sign <= 0, err <= 0; -> WAIT_A. No res_valid.
  - ADD/SUB/MUL (and DIV if enabled): latch op; -> WAIT_B.
  - Any other code: latch op as illegal, err <= 1; -> WAIT_B. This keeps alignment with the mux's 3-phase counter.
  - Only data[3:0] is decoded; data[7:4] is ignored.
- WAIT_B + valid:
  - B <= data.
  - Illegal op: -> WAIT_A; no res_valid, result unchanged.
  - Division (if enabled): -> EXEC.
  - Otherwise: -> DONE.
- DONE (1 cycle):
  - result/sign registered; res_valid=1 this cycle; -> WAIT_A.
  - Latency: B accepted on edge N -> res_valid high in cycle N+1.
- Arithmetic (unsigned inputs, results zero-extended to 2*WIDTH):
  - ADD: A+B, sign=0.
  - SUB: |A-B|, sign=(A<B).
  - MUL: full 2*WIDTH product, sign=0.
  - Example: 255*255 = 16'hFE01; 3-200 -> result 197, sign=1.
- Hold: result, sign and err hold until the next res_valid, clear, reset, or (err only) accepted A.
- Back-to-back: a new A may be accepted in the cycle after DONE. There are no bubbles beyond DONE.

Optional Feature:
- Macro: CALC_DIV_EN.
- Defined:
  - OP_DIV is legal. Unsigned restoring division, one quotient bit per cycle.
  - EXEC lasts WIDTH cycles, then DONE. res_valid fires in cycle N+WIDTH+1 (N+9 at default).
  - result = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}; sign=0.
  - B=0: skip EXEC, go to DONE next cycle; result=0, err=1, res_valid=1.
- Not defined:
  - 4'hf is an illegal operator (err=1, no result).
  - EXEC is unreachable and the divider logic is absent.

Test Plan:
- Reset then tokens 8'd25, 8'h0a, 8'd17 -> one res_valid pulse cycle after B, result=16'd42, sign=0, stage 0->1->2->3->0.
- Tokens 8'd3, 8'h0b, 8'd200 -> result=16'd197, sign=1; then 8'd255, 8'h0c, 8'd255 -> result=16'hFE01, sign=0.
- Tokens 8'd9, 8'h0d -> result=0, err=0, no res_valid, stage=0; next token 8'd4 is taken as A.
- Tokens 8'd5, 8'h01, 8'd7 -> err=1 after operator, no res_valid, result unchanged, stage back to 0; next A clears err.
- CALC_DIV_EN: 8'd200, 8'h0f, 8'd7 -> res_valid 9 cycles after B, result=16'h041C (rem 4, quot 28); valid pulses during EXEC ignored. Divisor 0 -> result=0, err=1.
- rst pulse during EXEC or WAIT_B -> all outputs 0, stage=0, no res_valid afterwards until a full new A/op/B sequence completes.
